// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: launch/capture/decode/average sequencer for one TDC delay line
module tdc_meas_ctrl #(
  parameter int N            = 64,
  parameter int AVG_LOG2_MAX = 3,
  parameter int CNT_W        = $clog2(N + 1),
  parameter int ACC_W        = CNT_W + AVG_LOG2_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       settle_i,
  input  logic [1:0]       avg_log2_i,
  output logic             launch_o,
  input  logic [N-1:0]     taps_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] result_o,
  output logic             bubble_o,
  output logic             valid_o,
  input  logic             ready_i
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LAUNCH = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] RELAX1 = 3'd3;
  localparam logic [2:0] RELAX2 = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [1:0] K_MAX  = 2'(AVG_LOG2_MAX);

  logic [2:0]       state;
  logic [3:0]       s_q;
  logic [3:0]       wait_cnt;
  logic [1:0]       k_q;
  logic [1:0]       k_clamped;
  logic [2:0]       smp_cnt;
  logic [3:0]       n_smp;
  logic             last_smp;
  logic [N-1:0]     cap_q;
  logic [ACC_W-1:0] acc;
  logic             bub_q;
  logic [CNT_W-1:0] cnt;
  logic             seen0;
  logic             smp_bub;

  assign busy_o    = state != IDLE;
  assign k_clamped = avg_log2_i > K_MAX ? K_MAX : avg_log2_i;
  assign n_smp     = 4'd1 << k_q;
  assign last_smp  = {1'b0, smp_cnt} == n_smp - 4'd1;

  // thermometer decode of the captured taps: leading run of ones plus bubble detect
  always_comb begin
    cnt     = '0;
    seen0   = 1'b0;
    smp_bub = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!cap_q[i]) seen0 = 1'b1;
      else if (seen0) smp_bub = 1'b1;
      else cnt = cnt + 1'b1;
    end
  end

  // measurement sequencer: launch, settle, capture, relax, accumulate, report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s_q      <= '0;
      wait_cnt <= '0;
      k_q      <= '0;
      smp_cnt  <= '0;
      cap_q    <= '0;
      acc      <= '0;
      bub_q    <= 1'b0;
      launch_o <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
      bubble_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          s_q      <= settle_i;
          k_q      <= k_clamped;
          acc      <= '0;
          smp_cnt  <= '0;
          bub_q    <= 1'b0;
          launch_o <= 1'b1;
          state    <= LAUNCH;
        end
        LAUNCH: begin
          wait_cnt <= s_q;
          if (s_q == 4'd0) begin
            cap_q    <= taps_i;
            launch_o <= 1'b0;
            state    <= RELAX1;
          end else state <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            cap_q    <= taps_i;
            launch_o <= 1'b0;
            state    <= RELAX1;
          end
        end
        RELAX1: begin
          acc   <= acc + ACC_W'(cnt);
          bub_q <= bub_q | smp_bub;
          state <= RELAX2;
        end
        RELAX2: begin
          if (last_smp) begin
            valid_o  <= 1'b1;
            result_o <= CNT_W'(acc >> k_q);
            bubble_o <= bub_q;
            state    <= DONE;
          end else begin
            smp_cnt  <= smp_cnt + 3'd1;
            launch_o <= 1'b1;
            state    <= LAUNCH;
          end
        end
        DONE: if (ready_i) begin
          valid_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
- Measurement sequencer for the TDC delay line: drives the line's launch input, captures the tap vector after a programmable settle time, decodes the thermometer code to a stage count, and optionally averages 2^K samples.
- Result is returned on a valid/ready handshake to the readout logic.
- Sits between the delay-line instance and the user-facing register/readout block; one controller per delay line.

Parameters:
- N, 64, number of delay-line taps (width of taps_i).
- AVG_LOG2_MAX, 3, maximum averaging exponent (up to 8 samples).
- CNT_W, $clog2(N+1), width of one decoded sample (0..N).
- ACC_W, CNT_W+AVG_LOG2_MAX, accumulator width.

Ports:
- clk  input  1  single system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start_i  input  1  measurement request; sampled only in IDLE.
- settle_i  input  4  settle count S: extra cycles launch_o is held before capture.
- avg_log2_i  input  2  averaging exponent K; values above AVG_LOG2_MAX clamp to AVG_LOG2_MAX.
- launch_o  output  1  registered edge source driving the delay-line input.
- taps_i  input  N  delay-line outputs; bit 0 is the first stage.
- busy_o  output  1  high in every state except IDLE.
- result_o  output  CNT_W  averaged stage count.
- bubble_o  output  1  one or more samples of this measurement were non-monotonic.
- valid_o  output  1  result_o and bubble_o are valid.
- ready_i  input  1  consumer accepts the result.

Behaviour:
- Reset (async, rst_n low) forces: state IDLE, launch_o=0, busy_o=0, valid_o=0, result_o=0, bubble_o=0, accumulator and sample counter cleared. Reset asserted mid-measurement aborts immediately; no result is produced.
- States are IDLE, LAUNCH, WAIT, RELAX1, RELAX2 and DONE.
- IDLE:
  - On a clk edge with start_i=1, latch settle_i into S_q and clamp(avg_log2_i) into K_q.
  - Clear the accumulator, sample counter and bubble flag.
  - Go to LAUNCH.
- LAUNCH (1 cycle): launch_o=1. Go to WAIT if S_q>0, else capture at this cycle's ending edge.
- WAIT (S_q cycles): launch_o stays 1.
- Capture:
  - taps_i is registered at the edge ending the last high cycle, i.e. S_q+1 edges after launch_o rose.
  - launch_o is driven 0 from that edge onward. Go to RELAX1.
- Decode (registered in RELAX1):
  - count = number of consecutive 1s starting at captured bit 0 (0..N).
  - sample_bubble = any 1 above the first 0.
  - acc += count; bubble flag |= sample_bubble.
- RELAX1, then RELAX2: launch_o=0, giving the line 2 cycles to clear. After RELAX2:
  - If sample counter == 2^K_q - 1, go to DONE.
  - Otherwise increment the counter and go to LAUNCH.
- Per-sample period is S_q+3 cycles.
- DONE:
  - valid_o=1, result_o = acc >> K_q (truncating), bubble_o = bubble flag.
  - Outputs are held stable while ready_i=0.
  - On an edge with valid_o & ready_i, clear valid_o and return to IDLE.
  - start_i in that same cycle is ignored; a new start must be seen in IDLE.
- Latency: start_i sampled at edge e0 -> launch_o high in cycles 1..S+1 -> valid_o high from cycle 2^K·(S+3)+1 after e0 (K=0: cycle S+4).
- Width rules:
  - Accumulator is ACC_W bits and cannot overflow: N·2^AVG_LOG2_MAX < 2^ACC_W.
  - result_o is always ≤ N.
- start_i while busy_o=1 is ignored; no queuing.
- settle_i and avg_log2_i are don't-care outside the IDLE start edge.
- Edge-case decodes: all-zero taps -> count 0; all-ones taps -> count N, no bubble.

Test Plan:
- Reset mid-WAIT (S=5, assert rst_n low in cycle 3) -> launch_o, busy_o, valid_o go 0 immediately without a clock; after release, IDLE and no valid_o.
- S=2, K=0, taps_i=0x0000_0000_0000_00FF at capture -> launch_o high cycles 1..3; valid_o rises in cycle 6; result_o=8, bubble_o=0.
- K=2, S=0, taps per sample give counts 10, 11, 11, 13 -> 4 launch pulses each 1 cycle wide, period 3 cycles; valid_o in cycle 13; result_o=11 (45>>2); bubble_o=0.
- Bubble, K=0: taps=0x...0_0000_0F0F -> result_o=4, bubble_o=1. Boundaries: all-ones -> 64 with bubble_o=0; all-zero -> 0.
- Backpressure: ready_i=0 for 10 cycles in DONE -> valid_o, result_o, bubble_o stable; start_i pulses during busy are ignored; accept -> IDLE, then a fresh start runs normally.
- avg_log2_i=3 with AVG_LOG2_MAX=2 -> exactly 4 launch pulses; result = sum>>2.
